// File: rtl/framer_pkg.sv
// Shared constants for the CRC-8 packet framer and its neighbouring crc8_calculator.
package framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CRC     = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h7E;
    localparam logic [8:0] CRC8_POLY         = 9'h107;

endpackage

// File: rtl/crc8_packet_framer.sv
// Transmit framer: SYNC, LEN, payload, CRC over a valid/ready byte stream.
// Drives an external crc8_calculator and appends its registered result.
module crc8_packet_framer
    import framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] length,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] crc_data,
    output logic       crc_calculate,
    output logic       crc_clear,
    input  logic [7:0] crc_in
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_len;
    logic [7:0] r_rem;
    logic       r_done;
    logic       w_accept;
    logic       w_start_ok;

    assign w_accept   = tx_valid & tx_ready;
    assign w_start_ok = (r_state == ST_IDLE) & start & ~abort;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_len   <= 8'd0;
            r_rem   <= 8'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_CRC) & w_accept & ~abort;
            if (w_start_ok) begin
                r_len <= length;
                r_rem <= length;
            end else if ((r_state == ST_PAYLOAD) && w_accept && (r_rem != 8'd0)) begin
                r_rem <= r_rem - 8'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (start) w_next = ST_SYNC;
                ST_SYNC:    if (w_accept) w_next = ST_LEN;
                ST_LEN:     if (w_accept) w_next = (r_len != 8'd0) ? ST_PAYLOAD : ST_CRC;
                ST_PAYLOAD: if (w_accept && (r_rem == 8'd1)) w_next = ST_CRC;
                ST_CRC:     if (w_accept) w_next = ST_IDLE;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    // The CRC byte needs no wait state: the calculator result registered on
    // the edge that accepted the last covered byte is already on crc_in.
    always_comb begin
        busy          = (r_state != ST_IDLE);
        done          = r_done;
        tx_data       = 8'd0;
        tx_valid      = 1'b0;
        pl_ready      = 1'b0;
        crc_data      = 8'd0;
        crc_calculate = 1'b0;
        crc_clear     = ~reset | abort | w_start_ok | ((r_state == ST_IDLE) & start);
        case (r_state)
            ST_SYNC: begin
                tx_data  = SYNC_BYTE;
                tx_valid = 1'b1;
            end
            ST_LEN: begin
                tx_data       = r_len;
                tx_valid      = 1'b1;
                crc_data      = r_len;
                crc_calculate = tx_ready & ~abort;
            end
            ST_PAYLOAD: begin
                tx_data       = pl_data;
                tx_valid      = pl_valid;
                pl_ready      = tx_ready;
                crc_data      = pl_data;
                crc_calculate = pl_valid & tx_ready & ~abort;
            end
            ST_CRC: begin
                tx_data  = crc_in;
                tx_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_crc8_packet_framer.sv
// Directed bench for crc8_packet_framer with a behavioural CRC-8 (poly 0x07,
// init 0) calculator model standing in for crc8_calculator.
module tb_crc8_packet_framer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] length = 8'd0;
    logic       abort = 1'b0;
    logic       busy, done;
    logic [7:0] pl_data = 8'd0;
    logic       pl_valid = 1'b0;
    logic       pl_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] crc_data;
    logic       crc_calculate, crc_clear;
    logic [7:0] crc_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pl_mem [8];
    logic [7:0] got [16];
    int got_n, calc_n, stall_err, plr_n, clash_n, done_n;
    bit done_lat_ok;

    always #5 clock = ~clock;

    crc8_packet_framer dut (
        .clock(clock), .reset(reset), .start(start), .length(length), .abort(abort),
        .busy(busy), .done(done), .pl_data(pl_data), .pl_valid(pl_valid),
        .pl_ready(pl_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .crc_data(crc_data), .crc_calculate(crc_calculate), .crc_clear(crc_clear),
        .crc_in(crc_in)
    );

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    logic [7:0] m_crc;
    always @(posedge clock or negedge reset) begin
        if (!reset)             m_crc <= 8'd0;
        else if (crc_clear)     m_crc <= 8'd0;
        else if (crc_calculate) m_crc <= crc8_step(m_crc, crc_data);
    end
    assign crc_in = m_crc;

    // Runs one frame; inputs change 1 time unit after posedge, outputs are sampled at negedge.
    task automatic run_frame(input logic [7:0] len, input logic [3:0] tx_pat,
                             input logic [3:0] pv_pat, input int poke_cyc);
        int idx, last_acc, end_cyc;
        logic stalled, acc_pl;
        logic [7:0] held;
        got_n = 0; calc_n = 0; stall_err = 0; plr_n = 0; clash_n = 0; done_n = 0;
        done_lat_ok = 0; idx = 0; last_acc = -10; end_cyc = 199;
        stalled = 0; acc_pl = 0; held = 8'd0;
        @(posedge clock); #1;
        start = 1'b1; length = len; tx_ready = tx_pat[0]; pl_valid = 1'b0;
        for (int cyc = 0; cyc <= end_cyc; cyc++) begin
            if (cyc > 0) begin
                @(posedge clock); #1;
                start = (cyc == poke_cyc);
                if (cyc == poke_cyc) length = len + 8'd3;
                tx_ready = tx_pat[cyc % 4];
                if (acc_pl) pl_valid = 1'b0;
                if (!pl_valid) pl_valid = (idx < int'(len)) && pv_pat[cyc % 4];
                pl_data = pl_mem[idx % 8];
            end
            @(negedge clock);
            if (stalled && (tx_valid !== 1'b1 || tx_data !== held)) stall_err++;
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            if (tx_valid && tx_ready) begin got[got_n % 16] = tx_data; got_n++; last_acc = cyc; end
            if (crc_calculate) calc_n++;
            if (crc_calculate && crc_clear) clash_n++;
            if (pl_ready) plr_n++;
            acc_pl = pl_valid && pl_ready;
            if (acc_pl) idx++;
            if (done === 1'b1) begin
                if (done_n == 0) begin
                    end_cyc = cyc + 2;
                    if (cyc == last_acc + 1) done_lat_ok = 1;
                end
                done_n++;
            end
        end
        pl_valid = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || tx_valid !== 1'b0 || pl_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b done=%b tx_valid=%b pl_ready=%b, required all 0",
                     busy, done, tx_valid, pl_ready);
        end
        n_checks++;
        if (crc_clear !== 1'b1 || crc_calculate !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_crc_ctrl clear=%b calc=%b, required 1/0", crc_clear, crc_calculate);
        end
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (crc_clear !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_clear got %b required 0", crc_clear);
        end
    endtask

    task automatic check_frame(input string name, input int n, input logic [7:0] e0,
                               input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3, input logic [7:0] e4, input int calcs);
        logic [7:0] ex [5];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3; ex[4] = e4;
        n_checks++;
        if (got_n !== n) begin
            n_fail++;
            $display("FAIL %s_count got %0d bytes required %0d", name, got_n, n);
        end
        for (int i = 0; i < n && i < 5; i++) begin
            n_checks++;
            if (got[i] !== ex[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d got %h required %h", name, i, got[i], ex[i]);
            end
        end
        n_checks++;
        if (done_n !== 1 || !done_lat_ok) begin
            n_fail++;
            $display("FAIL %s_done pulses=%0d latency_ok=%0d, required 1/1", name, done_n, done_lat_ok);
        end
        n_checks++;
        if (calc_n !== calcs || clash_n !== 0) begin
            n_fail++;
            $display("FAIL %s_calc got %0d (clash %0d) required %0d (0)", name, calc_n, clash_n, calcs);
        end
    endtask

    task automatic test_basic();
        pl_mem[0] = 8'h01; pl_mem[1] = 8'h02;
        run_frame(8'd2, 4'b1111, 4'b1111, -1);
        check_frame("basic", 5, 8'h7E, 8'h02, 8'h01, 8'h02, 8'hCD, 3);
    endtask

    task automatic test_zero_len();
        run_frame(8'd0, 4'b1111, 4'b1111, -1);
        check_frame("zero", 3, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        n_checks++;
        if (plr_n !== 0) begin
            n_fail++;
            $display("FAIL zero_pl_ready asserted %0d cycles, required 0", plr_n);
        end
    endtask

    task automatic test_stalls();
        pl_mem[0] = 8'h07;
        run_frame(8'd1, 4'b0101, 4'b1001, -1);
        check_frame("stall", 4, 8'h7E, 8'h01, 8'h07, 8'h00, 8'h00, 2);
        n_checks++;
        if (stall_err !== 0) begin
            n_fail++;
            $display("FAIL stall_hold unstable cycles %0d, required 0", stall_err);
        end
    endtask

    task automatic test_ignore_start();
        pl_mem[0] = 8'h01; pl_mem[1] = 8'h02;
        run_frame(8'd2, 4'b1111, 4'b1111, 3);
        check_frame("busy_start", 5, 8'h7E, 8'h02, 8'h01, 8'h02, 8'hCD, 3);
    endtask

    task automatic test_abort();
        @(posedge clock); #1;
        start = 1'b1; abort = 1'b1; length = 8'd3;
        @(negedge clock);
        n_checks++;
        if (crc_clear !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_start_clear got %b required 1", crc_clear);
        end
        @(posedge clock); #1; start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_beats_start busy=%b required 0", busy);
        end
        start = 1'b1; tx_ready = 1'b1; pl_valid = 1'b1; pl_data = 8'h01;
        @(posedge clock); #1; start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock); #1;
        pl_data = 8'h02; abort = 1'b1;
        @(negedge clock);
        n_checks++;
        if (crc_clear !== 1'b1 || crc_calculate !== 1'b0 || pl_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_cycle clear=%b calc=%b pl_ready=%b, required 1/0/1",
                     crc_clear, crc_calculate, pl_ready);
        end
        @(posedge clock); #1;
        abort = 1'b0; pl_valid = 1'b0; tx_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle busy=%b done=%b, required 0/0", busy, done);
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done done=%b required 0", done);
        end
        pl_mem[0] = 8'h01; pl_mem[1] = 8'h02;
        run_frame(8'd2, 4'b1111, 4'b1111, -1);
        check_frame("after_abort", 5, 8'h7E, 8'h02, 8'h01, 8'h02, 8'hCD, 3);
    endtask

    task automatic test_async_reset();
        @(posedge clock); #1;
        start = 1'b1; length = 8'd3; tx_ready = 1'b1; pl_valid = 1'b1; pl_data = 8'h01;
        @(posedge clock); #1; start = 1'b0;
        @(posedge clock);
        @(posedge clock); #3;
        n_checks++;
        if (busy !== 1'b1 || pl_ready !== 1'b1 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_payload busy=%b pl_ready=%b tx_valid=%b, required 1/1/1",
                     busy, pl_ready, tx_valid);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || pl_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async tx_valid=%b pl_ready=%b busy=%b done=%b, required 0",
                     tx_valid, pl_ready, busy, done);
        end
        pl_valid = 1'b0; tx_ready = 1'b0;
        @(negedge clock); reset = 1'b1;
        pl_mem[0] = 8'h01; pl_mem[1] = 8'h02;
        run_frame(8'd2, 4'b1111, 4'b1111, -1);
        check_frame("after_reset", 5, 8'h7E, 8'h02, 8'h01, 8'h02, 8'hCD, 3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stalls();
        test_ignore_start();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
